// File: rtl/arbiter_sched.sv
// arbiter_sched: fixed-priority, non-preemptive bus arbiter with a two-state
// FSM (IDLE / OWNED). A grant is held until the owner strobes done_i or drops
// its request. Each release is followed by an idle bubble cycle.
//
// Optional feature, enabled by defining ARB_STARVE_PROMOTE_EN:
// each port keeps a saturating wait counter. A requester whose counter has
// reached STARVE_LIMIT beats fixed priority. Without the macro, arbitration
// is pure fixed priority (bit 0 highest) and starved_o is tied to zero.
//
// Handshake: req_i is a level. A grant is issued at the first IDLE edge where
// req_i is non-zero, and gnt_o is visible one cycle later. gnt_o then stays
// constant until the edge where done_i=1 or req_i[owner]=0, which returns the
// FSM to IDLE with gnt_o cleared. done_i has no effect while IDLE.
// state_o is a debug view of the FSM (1 = OWNED).

module arbiter_sched #(
  parameter int NUM_PORTS    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic                         done_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  output logic                         gnt_valid_o,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_id_o,
  output logic [NUM_PORTS-1:0]         starved_o,
  output logic                         state_o
);

  localparam int IDW = $clog2(NUM_PORTS);

  // Parameter range guards, evaluated at elaboration
  if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_ports
    $error("arbiter_sched: NUM_PORTS must be in 2..16");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("arbiter_sched: STARVE_LIMIT must be in 1..255");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  state_t               state;
  logic [NUM_PORTS-1:0] promo_mask;
  logic [IDW-1:0]       win_id;
  logic [NUM_PORTS-1:0] win_oh;
  logic                 found;
  logic                 grant_edge;
  logic                 release_now;

  assign state_o = (state == S_OWNED);

  // A grant is taken at any IDLE edge with a pending request.
  assign grant_edge  = (state == S_IDLE) && (|req_i);
  // The owner lets go by strobing done_i or by dropping its request.
  assign release_now = done_i || !req_i[gnt_id_o];

`ifdef ARB_STARVE_PROMOTE_EN
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  logic [7:0] cnt     [NUM_PORTS];
  logic [7:0] cnt_nxt [NUM_PORTS];

  // Ports whose counter sits at the limit; masked with req_i so a promoted
  // port that has just dropped its request is never granted.
  assign promo_mask = req_i & starved_o;

  // Wait counter next state: clear on idle or on win, else count lost grants
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (!req_i[i]) begin
        cnt_nxt[i] = '0;
      end else if (grant_edge) begin
        if (win_id == IDW'(i)) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] != LIM) begin
          cnt_nxt[i] = cnt[i] + 8'd1;
        end
      end
    end
  end

  // Wait counters and the registered starvation flags that track them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt[i] <= '0;
      end
      starved_o <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt[i]       <= cnt_nxt[i];
        starved_o[i] <= (cnt_nxt[i] == LIM);
      end
    end
  end
`else
  assign promo_mask = '0;
  assign starved_o  = '0;
`endif

  // Winner pick: lowest promoted requester first, then lowest requester
  always_comb begin
    win_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && promo_mask[i]) begin
        win_id = IDW'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req_i[i]) begin
        win_id = IDW'(i);
        found  = 1'b1;
      end
    end
    win_oh         = '0;
    win_oh[win_id] = 1'b1;
  end

  // Grant FSM with registered grant outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      gnt_o       <= '0;
      gnt_valid_o <= 1'b0;
      gnt_id_o    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_edge) begin
            state       <= S_OWNED;
            gnt_o       <= win_oh;
            gnt_valid_o <= 1'b1;
            gnt_id_o    <= win_id;
          end
        end
        S_OWNED: begin
          if (release_now) begin
            state       <= S_IDLE;
            gnt_o       <= '0;
            gnt_valid_o <= 1'b0;
            gnt_id_o    <= '0;
          end
        end
        default: begin
          state       <= S_IDLE;
          gnt_o       <= '0;
          gnt_valid_o <= 1'b0;
          gnt_id_o    <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/arbiter_sched.md
ARBITER_SCHED -- requirements
Module: arbiter_sched

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, count of waiting arbitration decisions after which a requester is promoted (1..255).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port req_i, input, NUM_PORTS, per-port request level; bit 0 has the highest fixed priority.
REQ-006 SHALL have port done_i, input, 1, owner release strobe; ignored while no grant is held.
REQ-007 SHALL have port gnt_o, output, NUM_PORTS, registered one-hot grant; all-zero when idle.
REQ-008 SHALL have port gnt_valid_o, output, 1, high exactly when gnt_o is non-zero.
REQ-009 SHALL have port gnt_id_o, output, $clog2(NUM_PORTS), binary index of the owner; 0 when idle.
REQ-010 SHALL have port starved_o, output, NUM_PORTS, per-port flag, high while that port's wait counter equals STARVE_LIMIT.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (no owner) and OWNED (one owner held).
REQ-012 IDLE: if req_i is non-zero at a rising edge, SHALL load the winner into gnt_o at that edge and enter OWNED; otherwise it SHALL stay in IDLE.
REQ-013 Winner selection SHALL be the lowest-index requesting port, except as modified by REQ-020.
REQ-014 Grant latency SHALL be exactly one cycle: req_i sampled high at edge N gives gnt_o high after edge N.
REQ-015 OWNED: gnt_o SHALL remain constant regardless of other requests (no preemption).
REQ-016 OWNED: release SHALL occur when done_i=1 or req_i[owner]=0 at an edge; at that edge the FSM SHALL clear gnt_o and return to IDLE.
REQ-017 After a release, SHALL leave a mandatory one-cycle bubble: gnt_o is all-zero for at least one cycle before the next grant.
REQ-018 gnt_o SHALL never have more than one bit set, and SHALL never grant a port whose req_i was low at the granting edge.
REQ-019 Simultaneous done_i and new requests at the release edge SHALL still release first, and SHALL not grant in the same edge.

Reset
REQ-021 On rst_i=1 at an edge: FSM->IDLE; gnt_o=0; gnt_valid_o=0; gnt_id_o=0; starved_o=0; all wait counters=0.
REQ-022 Reset asserted while OWNED SHALL drop the grant at that edge; no grant SHALL be issued while rst_i=1.
REQ-023 The first grant after reset deassertion SHALL occur no earlier than the first edge with rst_i=0.

Configuration
REQ-020 With ARB_STARVE_PROMOTE_EN defined: each port SHALL keep a saturating wait counter, incremented at every IDLE-to-OWNED grant edge where that port requested but lost, and cleared when that port is granted or its req_i is low.
- Any port whose counter equals STARVE_LIMIT SHALL beat fixed priority; among several such ports, the lowest index SHALL win.
- starved_o SHALL reflect counter==STARVE_LIMIT, registered.
REQ-024 Without ARB_STARVE_PROMOTE_EN: counters SHALL not exist, arbitration SHALL be pure fixed priority, and starved_o SHALL be tied to 0.

Verification
REQ-025 Reset mid-grant: N=4, port 2 owning, rst_i=1 for one cycle -> gnt_o=0000 after that edge, gnt_valid_o=0, gnt_id_o=0.
REQ-026 Priority and latency: req_i=1010 from idle -> gnt_o=0010, gnt_id_o=1 one cycle later; it stays held while req_i changes to 1011.
REQ-027 Release and bubble: owner port 1, done_i=1 for one cycle with req_i=1111 -> gnt_o=0000 for exactly one cycle, then 0001.
REQ-028 Owner drop: owner port 3 deasserts req_i[3] -> gnt_o=0000 at the next edge, with no done_i.
REQ-029 Starvation (macro on, STARVE_LIMIT=3): ports 0 and 3 request continuously, and port 0 releases each grant -> after 3 lost decisions starved_o[3]=1 and the next grant is gnt_o=1000, then counter 3 clears.
REQ-030 Macro off, same stimulus as REQ-029 -> port 3 is never granted and starved_o stays 0000.
